pipe_stage_buffer: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, the successor to the fixed-field inter-stage registers between the CPU pipeline stages. It carries an opaque control vector and data vector from one stage to the next. It supports:
- backpressure (stall), via an optional two-entry skid buffer;
- flush (bubble insertion);
- saturating stall and bubble counters for the hazard unit and debug.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_buffer.sv | 137 +++++++++++++
 tb/tb_pipe_stage_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: default widths, main-entry routing and the counter saturation helper.
package pipe_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = INSTR_W;
  localparam int unsigned DEF_CTRL_W = 8;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned SAT_MAX_W  = 32;

  // Where the main (output-driving) entry takes its next value from
  typedef enum logic [1:0] {
    MAIN_HOLD      = 2'd0,
    MAIN_FROM_IN   = 2'd1,
    MAIN_FROM_SKID = 2'd2,
    MAIN_EMPTY     = 2'd3
  } main_sel_e;

  // Increment a counter of width w, sticking at 2^w-1 instead of wrapping
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt,
                                                   input int unsigned w);
    logic [SAT_MAX_W-1:0] max_v;
    max_v = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
    return (cnt >= max_v) ? max_v : cnt + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data entry; ctrl/data are cleared whenever the entry goes invalid.
module pipe_slot #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              drain,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Entry register: reset/flush win over load, load wins over drain
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      ctrl_q  <= d_ctrl;
      data_q  <= d_data;
    end else if (drain) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end
  end

  assign valid = valid_q;
  assign ctrl  = valid_q ? ctrl_q : '0;
  assign data  = valid_q ? data_q : '0;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Pipeline-stage register with valid/ready handshake, optional skid entry, flush and stall/bubble counters.
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic accept;
  logic rel;

  assign accept = in_valid && in_ready;
  assign rel    = out_valid && out_ready;

  if (SKID == 0) begin : g_single

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .load   (accept),
      .drain  (rel),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (out_valid),
      .ctrl   (out_ctrl),
      .data   (out_data)
    );

    // Single entry: a departing entry frees the slot in the same cycle
    assign in_ready = !rst && (!out_valid || out_ready);

  end else begin : g_skid

    main_sel_e         main_sel;
    logic              main_load;
    logic              main_drain;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic [DATA_W-1:0] main_d_data;
    logic              skid_load;
    logic              skid_drain;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Route accepts and releases between main and skid, keeping FIFO order
    always_comb begin
      main_sel   = MAIN_HOLD;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      if (rel && skid_valid) begin
        main_sel   = MAIN_FROM_SKID;
        skid_drain = 1'b1;
      end else if (accept && (!out_valid || rel)) begin
        main_sel = MAIN_FROM_IN;
      end else if (rel) begin
        main_sel = MAIN_EMPTY;
      end
      if (accept && out_valid && !rel) begin
        skid_load = 1'b1;
      end
    end

    assign main_load   = (main_sel == MAIN_FROM_IN) || (main_sel == MAIN_FROM_SKID);
    assign main_drain  = (main_sel == MAIN_EMPTY);
    assign main_d_ctrl = (main_sel == MAIN_FROM_SKID) ? skid_ctrl : in_ctrl;
    assign main_d_data = (main_sel == MAIN_FROM_SKID) ? skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .load   (main_load),
      .drain  (main_drain),
      .d_ctrl (main_d_ctrl),
      .d_data (main_d_data),
      .valid  (out_valid),
      .ctrl   (out_ctrl),
      .data   (out_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .load   (skid_load),
      .drain  (skid_drain),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );

    // Ready comes from the skid flop only, so out_ready never reaches in_ready
    assign in_ready = !rst && !skid_valid;

  end

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;

  // Saturating stall/bubble counters, sampled on the presented outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        stall_q <= CNT_W'(sat_inc(SAT_MAX_W'(stall_q), CNT_W));
      end
      if (!out_valid) begin
        bubble_q <= CNT_W'(sat_inc(SAT_MAX_W'(bubble_q), CNT_W));
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench: three instances (skid, single, skid with 4-bit counters) share one stimulus stream.
module tb_pipe_stage_buffer;

  localparam int unsigned NI = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;

  logic [NI-1:0] in_ready_w;
  logic [NI-1:0] out_valid_w;
  logic [7:0]    out_ctrl_w  [NI];
  logic [31:0]   out_data_w  [NI];
  logic [15:0]   stall_w     [NI];
  logic [15:0]   bubble_w    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned SK = (g == 1) ? 0 : 1;
    localparam int unsigned CW = (g == 2) ? 4 : 16;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;

    pipe_stage_buffer #(.DATA_W(32), .CTRL_W(8), .SKID(SK), .CNT_W(CW)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready_w[g]),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .flush      (flush),
      .out_valid  (out_valid_w[g]),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl_w[g]),
      .out_data   (out_data_w[g]),
      .stall_cnt  (sc),
      .bubble_cnt (bc)
    );

    assign stall_w[g]  = 16'(sc);
    assign bubble_w[g] = 16'(bc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each instance is a FIFO of {ctrl,data} with capacity 1 or 2
  logic [39:0] q [NI][$];
  int          e_stall [NI];
  int          e_bub   [NI];
  bit          mon_en;
  int          vectors;
  int          miscompares;

  function automatic bit has_skid(input int g);
    return g != 1;
  endfunction

  function automatic int cnt_max(input int g);
    return (g == 2) ? 15 : 65535;
  endfunction

  function automatic bit exp_ready(input int g, input int occ, input logic r, input logic rs);
    if (rs) return 1'b0;
    if (has_skid(g)) return occ < 2;
    return (occ == 0) || (r == 1'b1);
  endfunction

  task automatic chk(input string nm, input int g, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t got=%h expected=%h", nm, g, $time, got, exp);
    end
  endtask

  // Monitor: compare presented outputs against the model, then retire releases
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        for (int g = 0; g < NI; g++) begin
          int          occ;
          logic [39:0] exp_pl;
          occ    = q[g].size();
          exp_pl = (occ != 0) ? q[g][0] : 40'd0;
          chk("in_ready",   g, 64'(in_ready_w[g]), 64'(exp_ready(g, occ, out_ready, rst)));
          chk("out_valid",  g, 64'(out_valid_w[g]), 64'(occ != 0));
          chk("payload",    g, 64'({out_ctrl_w[g], out_data_w[g]}), 64'(exp_pl));
          chk("stall_cnt",  g, 64'(stall_w[g]), 64'(e_stall[g]));
          chk("bubble_cnt", g, 64'(bubble_w[g]), 64'(e_bub[g]));
          if (!rst) begin
            if (occ == 0) begin
              e_bub[g] = (e_bub[g] >= cnt_max(g)) ? cnt_max(g) : e_bub[g] + 1;
            end else if (!out_ready) begin
              e_stall[g] = (e_stall[g] >= cnt_max(g)) ? cnt_max(g) : e_stall[g] + 1;
            end
            if (occ != 0 && out_ready) void'(q[g].pop_front());
          end
        end
      end
    end
  end

  // Driver: apply one cycle of stimulus and push accepted entries into the scoreboard
  task automatic cycle(input logic v, input logic r, input logic f, input logic rs,
                       input logic [7:0] c, input logic [31:0] d);
    bit acc [NI];
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    rst       = rs;
    in_ctrl   = c;
    in_data   = d;
    #1;
    for (int g = 0; g < NI; g++) acc[g] = v && exp_ready(g, q[g].size(), r, rs);
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      if (rs) begin
        q[g].delete();
        e_stall[g] = 0;
        e_bub[g]   = 0;
      end else if (f) begin
        q[g].delete();
      end else if (acc[g]) begin
        q[g].push_back({c, d});
      end
    end
    if (rs) mon_en = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;
    in_ctrl     = 8'd0;
    in_data     = 32'd0;
    for (int g = 0; g < NI; g++) begin
      e_stall[g] = 0;
      e_bub[g]   = 0;
    end

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 32'd0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'(i + 1), 32'h1000_0000 + 32'(i));

    // Backpressure: offer A,B,C,... while blocked, then release
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0 + 8'(i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i), 32'hC000_0000 + 32'(i));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);

    // Fill, then flush together with a new offer D
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'hB0 + 8'(i), 32'hB000_0000 + 32'(i));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'hDD, 32'hDDDD_DDDD);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);

    // Idle long enough to saturate the 4-bit bubble counter
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);

    // Toggle out_ready each cycle under continuous offer
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'(i % 2), 1'b0, 1'b0, 8'(i), 32'h5000_0000 + 32'(i));

    // Random traffic with occasional flush and a two-cycle reset in the middle
    for (int i = 0; i < 400; i++) begin
      logic rs;
      rs = (i == 200) || (i == 201);
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 29) == 0), rs, 8'($urandom), 32'($urandom));
    end

    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd0);

    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
